// File: rtl/mask_row_sequencer_pkg.sv
// mask_seq_pkg: FSM state encoding, default parameters and counter widths for mask_row_sequencer
package mask_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_LOAD, ST_DONE} state_t;
  localparam int DEF_NUM_ROWS = 480;
  localparam int DEF_WORDS_PER_ROW = 20;
  localparam int DEF_LOAD_CYCLES = 2;
  localparam int WORD_W = 8;
  localparam int ROW_W = 10;
  localparam int LOAD_W = 4;
endpackage

// File: rtl/mask_row_sequencer_seq_counter.sv
// seq_counter: wrapping counter 0..MAX with clear/enable; ports clk, rst, clr, en in; tc out (count == MAX)
module seq_counter #(
  parameter int W = 8,
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(MAX);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/mask_row_sequencer.sv
// mask_row_sequencer: streams mask words row by row, then strobes ROW_LOAD; ports start/mask_* in, mSTREAM/STREAM_EN/ROWADD/ROW_LOAD/busy/done/stall_cnt out
module mask_row_sequencer
  import mask_seq_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int LOAD_CYCLES = DEF_LOAD_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mask_data,
  input  logic        mask_valid,
  output logic        mask_ready,
  output logic [16:1] mSTREAM,
  output logic        STREAM_EN,
  output logic [9:0]  ROWADD,
  output logic        ROW_LOAD,
  output logic        busy,
  output logic        done,
  output logic [15:0] stall_cnt
);
  state_t state;
  logic hs, go, load_exit, word_tc, row_tc, load_tc;
  assign mask_ready = state == ST_STREAM;
  assign hs = mask_valid && mask_ready;
  assign go = state == ST_IDLE && start;
  assign load_exit = state == ST_LOAD && load_tc;
  seq_counter #(.W(WORD_W), .MAX(WORDS_PER_ROW - 1)) u_word (
    .clk(clk), .rst(rst), .clr(go), .en(hs), .tc(word_tc));
  seq_counter #(.W(ROW_W), .MAX(NUM_ROWS - 1)) u_row (
    .clk(clk), .rst(rst), .clr(go), .en(load_exit && !row_tc), .tc(row_tc));
  seq_counter #(.W(LOAD_W), .MAX(LOAD_CYCLES - 1)) u_load (
    .clk(clk), .rst(rst), .clr(go), .en(state == ST_LOAD), .tc(load_tc));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      mSTREAM <= '0;
      STREAM_EN <= 1'b0;
      ROWADD <= '0;
      ROW_LOAD <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      stall_cnt <= '0;
    end else begin
      STREAM_EN <= hs;
      if (hs) mSTREAM <= mask_data;
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_STREAM;
          busy <= 1'b1;
          ROWADD <= '0;
          stall_cnt <= '0;
        end
        ST_STREAM:
          if (hs && word_tc) begin
            state <= ST_LOAD;
            ROW_LOAD <= 1'b1;
          end else if (!mask_valid) stall_cnt <= stall_cnt + {15'd0, ~&stall_cnt};
        ST_LOAD: if (load_tc) begin
          ROW_LOAD <= 1'b0;
          state <= row_tc ? ST_DONE : ST_STREAM;
          done <= row_tc;
          ROWADD <= row_tc ? ROWADD : ROWADD + 10'd1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
